// File: rtl/image_ram_arbiter_if.sv
// image_ram_arbiter_if: bundles the decoder write port, the filter
// read/write port and the single-port image RAM bus shared by the arbiter.
//   master : the arbiter's view (drives grants, read return and RAM bus)
//   slave  : the surroundings' view (decoder, filter controller, image RAM)
interface image_ram_arbiter_if #(
  parameter int IMAGE_RAM_ADDRESS_WIDTH = 17,
  parameter int PIXEL_WIDTH             = 8
);

  // Decoder write path
  logic                               dec_req;
  logic                               dec_last;
  logic [IMAGE_RAM_ADDRESS_WIDTH-1:0] dec_address;
  logic [PIXEL_WIDTH-1:0]             dec_data;
  logic                               dec_grant;

  // Filter controller read/write path
  logic                               flt_req;
  logic                               flt_last;
  logic                               flt_WE;
  logic [IMAGE_RAM_ADDRESS_WIDTH-1:0] flt_address;
  logic [PIXEL_WIDTH-1:0]             flt_data_in;
  logic [PIXEL_WIDTH-1:0]             flt_data_out;
  logic                               flt_data_valid;
  logic                               is_image_RAM_available;

  // Image RAM bus
  logic                               image_RAM_CE;
  logic                               image_RAM_WE;
  logic [IMAGE_RAM_ADDRESS_WIDTH-1:0] image_RAM_address;
  logic [PIXEL_WIDTH-1:0]             image_RAM_wdata;
  logic [PIXEL_WIDTH-1:0]             image_RAM_rdata;

  modport master (
    input  dec_req, dec_last, dec_address, dec_data,
    output dec_grant,
    input  flt_req, flt_last, flt_WE, flt_address, flt_data_in,
    output flt_data_out, flt_data_valid, is_image_RAM_available,
    output image_RAM_CE, image_RAM_WE, image_RAM_address, image_RAM_wdata,
    input  image_RAM_rdata
  );

  modport slave (
    output dec_req, dec_last, dec_address, dec_data,
    input  dec_grant,
    output flt_req, flt_last, flt_WE, flt_address, flt_data_in,
    input  flt_data_out, flt_data_valid, is_image_RAM_available,
    input  image_RAM_CE, image_RAM_WE, image_RAM_address, image_RAM_wdata,
    output image_RAM_rdata
  );

endinterface

// File: rtl/image_ram_arbiter.sv
// image_ram_arbiter: shares the single-port image RAM between the JPEG
// decoder write path and the filter controller. A requester owns the RAM
// for a burst of up to MAX_BURST accesses, ended by its last flag, by the
// burst limit or by dropping its request. Every ownership change passes
// through one dead TURNAROUND cycle. Filter reads return one cycle later
// with flt_data_valid.
//
// Build option: define IMAGE_ARB_ROUND_ROBIN_EN to alternate grants on a
// tie; otherwise the decoder always wins a tie.
module image_ram_arbiter #(
  parameter int IMAGE_RAM_ADDRESS_WIDTH = 17,
  parameter int PIXEL_WIDTH             = 8,
  parameter int MAX_BURST               = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  image_ram_arbiter_if.master  bus
);

  localparam int BEAT_W = $clog2(MAX_BURST + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);

`ifdef IMAGE_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT_DEC  = 2'd1,
    GRANT_FLT  = 2'd2,
    TURNAROUND = 2'd3
  } state_t;

  typedef enum logic {
    OWNER_DEC = 1'b0,
    OWNER_FLT = 1'b1
  } owner_t;

  state_t      state, next_state;
  owner_t      last_served, next_last_served;
  logic [BEAT_W-1:0] beat_cnt, next_beat_cnt;
  logic        dec_grant_q, flt_grant_q;
  logic        tie_to_flt;

  logic        ram_ce, ram_we;
  logic [IMAGE_RAM_ADDRESS_WIDTH-1:0] ram_address;
  logic [PIXEL_WIDTH-1:0]             ram_wdata;
  logic        flt_read;

  logic        rd_valid_q;
  logic [PIXEL_WIDTH-1:0] rd_hold_q;

  // On a tie the filter only wins when alternation is built in and the
  // decoder was the most recent owner.
  assign tie_to_flt = RR_EN && (last_served == OWNER_DEC);

  // State register, burst beat counter, tie history and registered grants
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      last_served <= OWNER_FLT;
      dec_grant_q <= 1'b0;
      flt_grant_q <= 1'b0;
    end else begin
      state       <= next_state;
      beat_cnt    <= next_beat_cnt;
      last_served <= next_last_served;
      dec_grant_q <= (next_state == GRANT_DEC);
      flt_grant_q <= (next_state == GRANT_FLT);
    end
  end

  // Arbitration, burst release and RAM bus mux driven by the owner
  // NOTE: every signal gets a default before the case so no path through
  // this block can leave one unassigned and infer a latch.
  always_comb begin
    next_state       = state;
    next_last_served = last_served;
    next_beat_cnt    = beat_cnt;
    ram_ce           = 1'b0;
    ram_we           = 1'b0;
    ram_address      = '0;
    ram_wdata        = '0;
    flt_read         = 1'b0;

    unique case (state)
      IDLE: begin
        next_beat_cnt = '0;
        if (bus.dec_req && bus.flt_req) begin
          next_state = tie_to_flt ? GRANT_FLT : GRANT_DEC;
        end else if (bus.dec_req) begin
          next_state = GRANT_DEC;
        end else if (bus.flt_req) begin
          next_state = GRANT_FLT;
        end
      end

      GRANT_DEC: begin
        ram_address = bus.dec_address;
        ram_wdata   = bus.dec_data;
        ram_ce      = bus.dec_req;
        ram_we      = bus.dec_req;
        if (bus.dec_req) begin
          next_beat_cnt = beat_cnt + BEAT_W'(1);
        end
        // A dropped request ends the burst just like last or the limit.
        if (!bus.dec_req || bus.dec_last || (beat_cnt == LAST_BEAT)) begin
          next_state       = TURNAROUND;
          next_last_served = OWNER_DEC;
        end
      end

      GRANT_FLT: begin
        ram_address = bus.flt_address;
        ram_wdata   = bus.flt_data_in;
        ram_ce      = bus.flt_req;
        ram_we      = bus.flt_req && bus.flt_WE;
        flt_read    = bus.flt_req && !bus.flt_WE;
        if (bus.flt_req) begin
          next_beat_cnt = beat_cnt + BEAT_W'(1);
        end
        if (!bus.flt_req || bus.flt_last || (beat_cnt == LAST_BEAT)) begin
          next_state       = TURNAROUND;
          next_last_served = OWNER_FLT;
        end
      end

      TURNAROUND: begin
        next_beat_cnt = '0;
        next_state    = IDLE;
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Filter read return: valid one cycle after a read access, data held
  // between reads
  // NOTE: the image RAM array itself is never reset; only this small
  // capture register is, so flt_data_out reads 0 out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_q <= 1'b0;
      rd_hold_q  <= '0;
    end else begin
      rd_valid_q <= flt_read;
      if (rd_valid_q) begin
        rd_hold_q <= bus.image_RAM_rdata;
      end
    end
  end

  assign bus.dec_grant              = dec_grant_q;
  assign bus.is_image_RAM_available = flt_grant_q;
  assign bus.flt_data_valid         = rd_valid_q;
  // The RAM's data arrives during the valid cycle, so it is passed straight
  // through then and replaced by the held copy afterwards.
  assign bus.flt_data_out           = rd_valid_q ? bus.image_RAM_rdata : rd_hold_q;

  assign bus.image_RAM_CE           = ram_ce;
  assign bus.image_RAM_WE           = ram_we;
  assign bus.image_RAM_address      = ram_address;
  assign bus.image_RAM_wdata        = ram_wdata;

endmodule

// File: doc/image_ram_arbiter.md
Name: image_ram_arbiter

Overview:
- Shares the single-port image RAM between two requesters: the JPEG decoder write path (decoded pixels in) and the filter controller (read/write of pixels for filtering).
- Grants burst ownership, muxes address, data and write-enable onto the RAM, and returns read data with a valid strobe.
- Generates the filter controller's is_image_RAM_available.
- Sits between the decoder output stage, the filter controller and the image RAM.

Parameters:
IMAGE_RAM_ADDRESS_WIDTH, 17, image RAM address width (320x240 image)
PIXEL_WIDTH, 8, RAM data width
MAX_BURST, 64, maximum accesses per grant (one 8x8 block)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
dec_req  in  1  decoder requests / holds RAM
dec_last  in  1  decoder marks final access of its burst
dec_address  in  IMAGE_RAM_ADDRESS_WIDTH  decoder write address
dec_data  in  PIXEL_WIDTH  decoder write data
dec_grant  out  1  decoder owns RAM
flt_req  in  1  filter requests / holds RAM
flt_last  in  1  filter marks final access of its burst
flt_WE  in  1  filter access is a write (0 = read)
flt_address  in  IMAGE_RAM_ADDRESS_WIDTH  filter address
flt_data_in  in  PIXEL_WIDTH  filter write data
flt_data_out  out  PIXEL_WIDTH  read data returned to filter
flt_data_valid  out  1  flt_data_out valid this cycle
is_image_RAM_available  out  1  filter owns RAM (filter grant)
image_RAM_CE  out  1  RAM chip enable
image_RAM_WE  out  1  RAM write enable
image_RAM_address  out  IMAGE_RAM_ADDRESS_WIDTH  RAM address
image_RAM_wdata  out  PIXEL_WIDTH  RAM write data
image_RAM_rdata  in  PIXEL_WIDTH  RAM read data, synchronous, 1-cycle latency

Behaviour:
- Reset (rst=0, async): state IDLE; dec_grant=0, is_image_RAM_available=0, flt_data_valid=0, flt_data_out=0, beat counter=0, last_served=FILTER (decoder wins first tie). RAM outputs are all 0 (CE=0, WE=0).
- States: IDLE, GRANT_DEC, GRANT_FLT, TURNAROUND.
- IDLE:
  - Arbitrate on the registered requests.
  - dec_req only -> GRANT_DEC. flt_req only -> GRANT_FLT. Neither -> stay.
  - Both -> policy (see Optional Feature).
- Grant outputs are registered:
  - dec_grant=1 exactly in GRANT_DEC.
  - is_image_RAM_available=1 exactly in GRANT_FLT.
  - The first access is possible in the first grant cycle, i.e. the cycle after the request is seen in IDLE.
- Access in a grant state: each cycle the owner's req=1 is one access. image_RAM_CE=1, and address/data/WE are driven combinationally from the owner's inputs, muxed by the registered state.
  - Decoder access: WE=1.
  - Filter access: WE=flt_WE.
  - Owner req=0: CE=0 and WE=0, no access.
- Beat counter increments per access and is cleared on grant entry.
- Release: leave the grant state to TURNAROUND after the access cycle in which any of the following holds:
  - owner last=1,
  - beat counter reaches MAX_BURST,
  - owner req=0 (drop without last).
  - Simultaneous last=1 and counter=MAX_BURST is a single release.
  - On release, last_served is set to the owner.
- TURNAROUND: one cycle, both grants 0, CE=0, then IDLE. Guarantees one idle RAM cycle between owners.
- A non-owner request is held pending; it is never dropped by the arbiter.
- Read return:
  - flt_data_valid=1 exactly one cycle after a filter read access (CE=1, WE=0).
  - flt_data_out captures image_RAM_rdata in that cycle and holds its value otherwise.
  - A read issued in the last grant cycle still returns valid during TURNAROUND.
- Writes by the decoder never raise flt_data_valid.
- Reset mid-burst: ownership is aborted immediately and the in-flight read valid is discarded.
- Signals that are not granted have no effect on the RAM outputs.
- Beat counter width is clog2(MAX_BURST+1).

Optional Feature:
- Macro IMAGE_ARB_ROUND_ROBIN_EN.
- Defined: on a tie in IDLE, grant the requester that is not last_served (alternate).
- Undefined: fixed priority; the decoder always wins ties. last_served is still maintained but ignored.
- All other behaviour is identical in both builds.

Test Plan:
- Reset then dec_req=1 alone with 64 writes (address 0..63, data=address): dec_grant rises 1 cycle after req. Expect 64 cycles CE=1, WE=1, RAM address 0..63. Forced release at beat 64, one TURNAROUND cycle with CE=0, then IDLE.
- flt_req=1 alone, reads at address 100..103 with flt_last on the 4th: is_image_RAM_available=1, WE=0. With the RAM model returning 8'h33, flt_data_valid pulses 4 cycles, each lagging its access by 1, with flt_data_out=8'h33. The 4th valid occurs in TURNAROUND.
- dec_req and flt_req asserted together from IDLE, repeated 3 times with 2-beat bursts:
  - With IMAGE_ARB_ROUND_ROBIN_EN, grant order is DEC, FLT, DEC.
  - Without it, grant order is DEC, DEC, DEC.
- Filter write burst (flt_WE=1, address 5, data 8'hA5, flt_last=1) while dec_req is pending: RAM sees one write to 5 of A5, no flt_data_valid. TURNAROUND, then dec_grant.
- Owner drops req mid-burst at beat 10 without last: release to TURNAROUND; the pending requester is granted 2 cycles later.
- rst=0 asserted mid filter-read burst: all outputs 0 asynchronously, and no flt_data_valid after reset release. The next tie goes to the decoder.
